// File: rtl/bm_buf_link_engine.sv
// bm_buf_link_engine
// Buffer-manager linked-list engine.
//   - Keeps the next-buffer pointer of every enqueued buffer in a 1R1W RAM.
//   - Answers dequeue next-pointer lookups with a fixed 4-cycle latency.
//   - Expands read-count (copy-count) commands into one update per buffer of
//     a packet by walking the chain. Lookups own the RAM read port; a walk
//     step that collides with a lookup is parked and replayed.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   enq_buf_valid/_ptr_cur/_ptr_nxt   link write (mem[cur] <= nxt)
//   packet_buf_req/_req_ptr           next-pointer lookup request
//   asa_bm_*                          read-count command (head, port, count, length)
//   inc_ll_rd_count/inc_ll_wr_count   statistics pulses
//   packet_ack_buf_valid/_ptr         lookup response
//   read_count_valid/_port_id/_buf_ptr, read_count   per-buffer update
module bm_buf_link_engine #(
    parameter int BUF_PTR_NBITS       = 10,
    parameter int PORT_ID_NBITS       = 4,
    parameter int READ_COUNT_NBITS    = 4,
    parameter int PACKET_LENGTH_NBITS = 14,
    parameter int BUF_SIZE            = 64,
    parameter int FIFO_DEPTH          = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enq_buf_valid,
    input  logic [BUF_PTR_NBITS-1:0]       enq_buf_ptr_cur,
    input  logic [BUF_PTR_NBITS-1:0]       enq_buf_ptr_nxt,
    input  logic                           packet_buf_req,
    input  logic [BUF_PTR_NBITS-1:0]       packet_buf_req_ptr,
    input  logic                           asa_bm_read_count_valid,
    input  logic [BUF_PTR_NBITS-1:0]       asa_bm_buf_ptr,
    input  logic [PORT_ID_NBITS-1:0]       asa_bm_rc_port_id,
    input  logic [READ_COUNT_NBITS-1:0]    asa_bm_read_count,
    input  logic [PACKET_LENGTH_NBITS-1:0] asa_bm_packet_length,
    output logic                           inc_ll_rd_count,
    output logic                           inc_ll_wr_count,
    output logic                           packet_ack_buf_valid,
    output logic [BUF_PTR_NBITS-1:0]       packet_ack_buf_ptr,
    output logic                           read_count_valid,
    output logic [PORT_ID_NBITS-1:0]       read_count_port_id,
    output logic [BUF_PTR_NBITS-1:0]       read_count_buf_ptr,
    output logic [READ_COUNT_NBITS-1:0]    read_count
);

    localparam int FIFO_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FIFO_CW = FIFO_AW + 1;
    localparam int LEN_W   = PACKET_LENGTH_NBITS + 1;
    localparam int CMD_W   = BUF_PTR_NBITS + PORT_ID_NBITS + READ_COUNT_NBITS + PACKET_LENGTH_NBITS;
    localparam logic [LEN_W-1:0] BUF_BYTES = LEN_W'(BUF_SIZE);

    typedef enum logic {RC_IDLE, RC_WALK} rc_state_t;

    rc_state_t rc_state;

    logic                       enq_v_r;
    logic [BUF_PTR_NBITS-1:0]   enq_cur_r, enq_nxt_r;
    logic [BUF_PTR_NBITS-1:0]   mem [0:(1<<BUF_PTR_NBITS)-1];
    logic [BUF_PTR_NBITS-1:0]   dout, deq_ptr, saved_ptr, req_ptr_d1;
    logic                       req_d1, req_d2, req_d3;
    logic                       cmd_v_d1, cmd_v_d2;
    logic [CMD_W-1:0]           cmd_in, cmd_d1, cmd_d2, fifo_head;
    logic [CMD_W-1:0]           fifo_mem [0:FIFO_DEPTH-1];
    logic [FIFO_AW-1:0]         wr_idx, rd_idx;
    logic [FIFO_CW-1:0]         fifo_cnt;
    logic                       fifo_empty, fifo_full, fifo_wr;
    logic [BUF_PTR_NBITS-1:0]   f_ptr;
    logic [PORT_ID_NBITS-1:0]   f_port;
    logic [READ_COUNT_NBITS-1:0] f_cnt;
    logic [PACKET_LENGTH_NBITS-1:0] f_len;
    logic [LEN_W-1:0]           remaining;
    logic                       rc_st, rc_sop, pending, wk_d1, wk_d2;
    logic                       pop, nxt, collide, first_eop, eop;
    logic [BUF_PTR_NBITS-1:0]   walk_ptr;

    function automatic logic [FIFO_AW-1:0] inc_idx(input logic [FIFO_AW-1:0] i);
        return (i == FIFO_AW'(FIFO_DEPTH - 1)) ? '0 : i + FIFO_AW'(1);
    endfunction

    assign cmd_in    = {asa_bm_buf_ptr, asa_bm_rc_port_id, asa_bm_read_count, asa_bm_packet_length};
    assign fifo_head = fifo_mem[rd_idx];
    assign {f_ptr, f_port, f_cnt, f_len} = fifo_head;
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == FIFO_CW'(FIFO_DEPTH));
    // Zero-length commands carry no buffers; overflow writes are dropped
    // because the sender guarantees the command rate.
    assign fifo_wr   = cmd_v_d2 && (cmd_d2[PACKET_LENGTH_NBITS-1:0] != '0) && !fifo_full;

    assign rc_st     = (rc_state == RC_WALK);
    assign pop       = !req_d1 && !fifo_empty && !rc_st;
    assign first_eop = ({1'b0, f_len} <= BUF_BYTES);
    assign eop       = rc_sop ? first_eop : (remaining <= BUF_BYTES);
    // wk_d2 marks that the RAM result of a walk read is on dout this cycle.
    assign nxt       = !req_d1 && rc_st && (wk_d2 || pending);
    // A lookup steals the read port exactly when a walk result is due:
    // park that result so the step can be replayed later.
    assign collide   = req_d1 && rc_st && wk_d2;
    assign walk_ptr  = pending ? saved_ptr : dout;

    assign inc_ll_wr_count = enq_v_r;
    assign inc_ll_rd_count = req_d1;

    // Link RAM: one write port, one registered read port (read-old-data).
    always_ff @(posedge clk) begin
        if (enq_v_r) mem[enq_cur_r] <= enq_nxt_r;
        dout <= mem[deq_ptr];
    end

    // Control state, strobes and FIFO bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rc_state             <= RC_IDLE;
            rc_sop               <= 1'b1;
            pending              <= 1'b0;
            remaining            <= '0;
            wk_d1                <= 1'b0;
            wk_d2                <= 1'b0;
            enq_v_r              <= 1'b0;
            req_d1               <= 1'b0;
            req_d2               <= 1'b0;
            req_d3               <= 1'b0;
            cmd_v_d1             <= 1'b0;
            cmd_v_d2             <= 1'b0;
            packet_ack_buf_valid <= 1'b0;
            read_count_valid     <= 1'b0;
            wr_idx               <= '0;
            rd_idx               <= '0;
            fifo_cnt             <= '0;
        end else begin
            enq_v_r              <= enq_buf_valid;
            req_d1               <= packet_buf_req;
            req_d2               <= req_d1;
            req_d3               <= req_d2;
            packet_ack_buf_valid <= req_d3;
            cmd_v_d1             <= asa_bm_read_count_valid;
            cmd_v_d2             <= cmd_v_d1;
            read_count_valid     <= pop || nxt;
            wk_d1                <= (pop && !first_eop) || (nxt && !eop);
            wk_d2                <= wk_d1;

            if (fifo_wr) wr_idx <= inc_idx(wr_idx);
            if (pop)     rd_idx <= inc_idx(rd_idx);
            case ({fifo_wr, pop})
                2'b10:   fifo_cnt <= fifo_cnt + FIFO_CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - FIFO_CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase

            if (pop) begin
                remaining <= {1'b0, f_len} - BUF_BYTES;
                if (!first_eop) begin
                    rc_state <= RC_WALK;
                    rc_sop   <= 1'b0;
                end
            end else if (nxt) begin
                remaining <= remaining - BUF_BYTES;
                if (eop) begin
                    rc_state <= RC_IDLE;
                    rc_sop   <= 1'b1;
                end
            end

            if (collide)  pending <= 1'b1;
            else if (nxt) pending <= 1'b0;
        end
    end

    // Unreset datapath: input stages, FIFO storage, read address and outputs.
    always_ff @(posedge clk) begin
        enq_cur_r          <= enq_buf_ptr_cur;
        enq_nxt_r          <= enq_buf_ptr_nxt;
        req_ptr_d1         <= packet_buf_req_ptr;
        cmd_d1             <= cmd_in;
        cmd_d2             <= cmd_d1;
        packet_ack_buf_ptr <= dout;
        if (fifo_wr) fifo_mem[wr_idx] <= cmd_d2;
        if (collide) saved_ptr <= dout;

        if (req_d1)       deq_ptr <= req_ptr_d1;
        else if (pop)     deq_ptr <= f_ptr;
        else if (pending) deq_ptr <= saved_ptr;
        else              deq_ptr <= dout;

        if (pop) begin
            read_count_buf_ptr <= f_ptr;
            read_count_port_id <= f_port;
            read_count         <= f_cnt;
        end else if (nxt) begin
            read_count_buf_ptr <= walk_ptr;
        end
    end

endmodule

// File: tb/tb_bm_buf_link_engine.sv
// tb_bm_buf_link_engine
// Self-checking bench for bm_buf_link_engine: fixed link/lookup checks,
// a table of read-count commands, hand-written multi-cycle corner cases,
// and randomized commands with concurrent lookups against a chain model.
module tb_bm_buf_link_engine;

    logic       clk, rst_n;
    logic       enq_buf_valid;
    logic [9:0] enq_buf_ptr_cur, enq_buf_ptr_nxt;
    logic       packet_buf_req;
    logic [9:0] packet_buf_req_ptr;
    logic       asa_bm_read_count_valid;
    logic [9:0] asa_bm_buf_ptr;
    logic [3:0] asa_bm_rc_port_id, asa_bm_read_count;
    logic [13:0] asa_bm_packet_length;
    logic       inc_ll_rd_count, inc_ll_wr_count;
    logic       packet_ack_buf_valid;
    logic [9:0] packet_ack_buf_ptr;
    logic       read_count_valid;
    logic [3:0] read_count_port_id, read_count;
    logic [9:0] read_count_buf_ptr;

    bm_buf_link_engine dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .enq_buf_valid           (enq_buf_valid),
        .enq_buf_ptr_cur         (enq_buf_ptr_cur),
        .enq_buf_ptr_nxt         (enq_buf_ptr_nxt),
        .packet_buf_req          (packet_buf_req),
        .packet_buf_req_ptr      (packet_buf_req_ptr),
        .asa_bm_read_count_valid (asa_bm_read_count_valid),
        .asa_bm_buf_ptr          (asa_bm_buf_ptr),
        .asa_bm_rc_port_id       (asa_bm_rc_port_id),
        .asa_bm_read_count       (asa_bm_read_count),
        .asa_bm_packet_length    (asa_bm_packet_length),
        .inc_ll_rd_count         (inc_ll_rd_count),
        .inc_ll_wr_count         (inc_ll_wr_count),
        .packet_ack_buf_valid    (packet_ack_buf_valid),
        .packet_ack_buf_ptr      (packet_ack_buf_ptr),
        .read_count_valid        (read_count_valid),
        .read_count_port_id      (read_count_port_id),
        .read_count_buf_ptr      (read_count_buf_ptr),
        .read_count              (read_count)
    );

    typedef struct { int cyc; logic [9:0] ptr; logic [3:0] port; logic [3:0] cnt; } upd_t;
    typedef struct { int cyc; logic [9:0] ptr; } ack_t;
    typedef struct {
        logic [9:0] ptr; logic [3:0] port; logic [3:0] cnt; logic [13:0] len;
        int n; logic [3:0][9:0] e;
    } vec_t;

    upd_t obs_upd[$], exp_upd[$];
    ack_t obs_ack[$], exp_ack[$];
    int   obs_rd[$], obs_wr[$];
    upd_t mon_u;
    ack_t mon_a;
    int   nextp [0:1023];
    int   cyc = 0;
    int   n_cmp = 0, n_fail = 0;
    vec_t tbl [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index: stimulus set at a negedge belongs to the current cyc.
    always @(posedge clk) cyc <= cyc + 1;

    // Record every output event with the cycle it was seen in.
    always @(negedge clk) begin
        if (rst_n) begin
            if (read_count_valid) begin
                mon_u.cyc = cyc; mon_u.ptr = read_count_buf_ptr;
                mon_u.port = read_count_port_id; mon_u.cnt = read_count;
                obs_upd.push_back(mon_u);
            end
            if (packet_ack_buf_valid) begin
                mon_a.cyc = cyc; mon_a.ptr = packet_ack_buf_ptr;
                obs_ack.push_back(mon_a);
            end
            if (inc_ll_rd_count) obs_rd.push_back(cyc);
            if (inc_ll_wr_count) obs_wr.push_back(cyc);
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // All drivers assume they start at a negedge and leave at the next one.
    task automatic linkWrite(input int cur, input int nxt);
        enq_buf_valid = 1'b1; enq_buf_ptr_cur = 10'(cur); enq_buf_ptr_nxt = 10'(nxt);
        nextp[cur] = nxt;
        @(negedge clk);
        enq_buf_valid = 1'b0;
    endtask

    task automatic lookupReq(input int p, output int c);
        c = cyc;
        packet_buf_req = 1'b1; packet_buf_req_ptr = 10'(p);
        @(negedge clk);
        packet_buf_req = 1'b0;
    endtask

    task automatic applyStimulus(input int p, input int port, input int cnt, input int len, output int c);
        c = cyc;
        asa_bm_read_count_valid = 1'b1; asa_bm_buf_ptr = 10'(p);
        asa_bm_rc_port_id = 4'(port); asa_bm_read_count = 4'(cnt); asa_bm_packet_length = 14'(len);
        @(negedge clk);
        asa_bm_read_count_valid = 1'b0;
    endtask

    // Reference model: one update per started 64-byte buffer, following the chain.
    task automatic modelCommand(input int p, input int port, input int cnt, input int len);
        upd_t u;
        int cur = p;
        for (int i = 0; i < (len + 63) / 64; i++) begin
            u.cyc = 0; u.ptr = 10'(cur); u.port = 4'(port); u.cnt = 4'(cnt);
            exp_upd.push_back(u);
            cur = nextp[cur];
        end
    endtask

    function automatic vec_t mkVec(int p, int port, int cnt, int len, int n, int e0, int e1, int e2, int e3);
        vec_t v;
        v.ptr = 10'(p); v.port = 4'(port); v.cnt = 4'(cnt); v.len = 14'(len); v.n = n;
        v.e[0] = 10'(e0); v.e[1] = 10'(e1); v.e[2] = 10'(e2); v.e[3] = 10'(e3);
        return v;
    endfunction

    function automatic int updPtr(int i);
        return (i < obs_upd.size()) ? int'(obs_upd[i].ptr) : -1;
    endfunction

    function automatic int updCyc(int i);
        return (i < obs_upd.size()) ? obs_upd[i].cyc : -1;
    endfunction

    initial begin
        int c, c2, k, p, lc;
        int chain [40];
        int pool [$];

        tbl[0] = mkVec(5, 2,  3,  64, 1, 5, 0, 0, 0);
        tbl[1] = mkVec(5, 1,  7, 150, 3, 5, 9, 3, 0);
        tbl[2] = mkVec(5, 4,  1,   0, 0, 0, 0, 0, 0);
        tbl[3] = mkVec(9, 3,  2,  65, 2, 9, 3, 0, 0);
        tbl[4] = mkVec(5, 0, 15, 256, 4, 5, 9, 3, 7);
        tbl[5] = mkVec(3, 5,  5,   1, 1, 3, 0, 0, 0);
        tbl[6] = mkVec(9, 6,  4, 128, 2, 9, 3, 0, 0);
        tbl[7] = mkVec(5, 15, 8, 129, 3, 5, 9, 3, 0);

        for (int i = 0; i < 1024; i++) nextp[i] = 0;
        rst_n = 1'b0;
        enq_buf_valid = 1'b0; enq_buf_ptr_cur = '0; enq_buf_ptr_nxt = '0;
        packet_buf_req = 1'b0; packet_buf_req_ptr = '0;
        asa_bm_read_count_valid = 1'b0; asa_bm_buf_ptr = '0;
        asa_bm_rc_port_id = '0; asa_bm_read_count = '0; asa_bm_packet_length = '0;
        waitCycles(3);
        checkOutput("reset_rc_valid", read_count_valid, 0);
        checkOutput("reset_ack_valid", packet_ack_buf_valid, 0);
        checkOutput("reset_rd_pulse", inc_ll_rd_count, 0);
        checkOutput("reset_wr_pulse", inc_ll_wr_count, 0);
        rst_n = 1'b1;
        waitCycles(1);

        // Link writes and the write statistics pulse.
        obs_wr.delete();
        c = cyc;
        linkWrite(5, 9);
        waitCycles(2);
        checkOutput("wr_pulse_count", obs_wr.size(), 1);
        checkOutput("wr_pulse_cycle", (obs_wr.size() > 0) ? obs_wr[0] - c : -1, 1);
        linkWrite(9, 3); linkWrite(3, 7); linkWrite(7, 12);
        waitCycles(3);

        // Single lookup: pulse at +1, ack at +4 with next pointer.
        obs_rd.delete(); obs_ack.delete();
        lookupReq(5, c);
        waitCycles(7);
        checkOutput("rd_pulse_count", obs_rd.size(), 1);
        checkOutput("rd_pulse_cycle", (obs_rd.size() > 0) ? obs_rd[0] - c : -1, 1);
        checkOutput("ack_count", obs_ack.size(), 1);
        checkOutput("ack_cycle", (obs_ack.size() > 0) ? obs_ack[0].cyc - c : -1, 4);
        checkOutput("ack_ptr", (obs_ack.size() > 0) ? int'(obs_ack[0].ptr) : -1, 9);

        // Table of commands on the chain 5->9->3->7.
        for (int t = 0; t < 8; t++) begin
            obs_upd.delete();
            applyStimulus(tbl[t].ptr, tbl[t].port, tbl[t].cnt, tbl[t].len, c);
            waitCycles(24);
            checkOutput($sformatf("tbl%0d_count", t), obs_upd.size(), tbl[t].n);
            for (int i = 0; i < tbl[t].n; i++) begin
                checkOutput($sformatf("tbl%0d_ptr%0d", t, i), updPtr(i), tbl[t].e[i]);
                checkOutput($sformatf("tbl%0d_cyc%0d", t, i), updCyc(i) - c, 4 + 2 * i);
                if (i < obs_upd.size()) begin
                    checkOutput($sformatf("tbl%0d_port%0d", t, i), obs_upd[i].port, tbl[t].port);
                    checkOutput($sformatf("tbl%0d_cnt%0d", t, i), obs_upd[i].cnt, tbl[t].cnt);
                end
            end
        end

        // Two single-buffer commands back-to-back give consecutive updates.
        obs_upd.delete();
        applyStimulus(5, 1, 2, 64, c);
        applyStimulus(9, 3, 4, 64, c2);
        waitCycles(10);
        checkOutput("b2b_count", obs_upd.size(), 2);
        checkOutput("b2b_ptr0", updPtr(0), 5);
        checkOutput("b2b_ptr1", updPtr(1), 9);
        checkOutput("b2b_cyc0", updCyc(0) - c, 4);
        checkOutput("b2b_cyc1", updCyc(1) - c, 5);
        if (obs_upd.size() > 1) checkOutput("b2b_port1", obs_upd[1].port, 3);

        // Lookup colliding with the first walk step of a 3-buffer packet.
        obs_upd.delete(); obs_ack.delete();
        applyStimulus(5, 7, 6, 192, c);
        waitCycles(3);
        lookupReq(9, lc);
        waitCycles(14);
        checkOutput("col_lookup_at", lc - c, 4);
        checkOutput("col_count", obs_upd.size(), 3);
        checkOutput("col_ptr0", updPtr(0), 5);
        checkOutput("col_ptr1", updPtr(1), 9);
        checkOutput("col_ptr2", updPtr(2), 3);
        checkOutput("col_cyc1", updCyc(1) - c, 7);
        checkOutput("col_cyc2", updCyc(2) - c, 9);
        checkOutput("col_ack_count", obs_ack.size(), 1);
        checkOutput("col_ack_cycle", (obs_ack.size() > 0) ? obs_ack[0].cyc - lc : -1, 4);
        checkOutput("col_ack_ptr", (obs_ack.size() > 0) ? int'(obs_ack[0].ptr) : -1, 3);

        // Reset in the middle of a walk.
        obs_upd.delete();
        applyStimulus(5, 2, 2, 192, c);
        waitCycles(3);
        checkOutput("rst_pre_valid", read_count_valid, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_valid_drop", read_count_valid, 0);
        waitCycles(3);
        rst_n = 1'b1;
        obs_upd.delete();
        waitCycles(12);
        checkOutput("rst_no_update", obs_upd.size(), 0);

        // Random chain of 40 distinct buffers outside the fixed ones.
        for (int v = 100; v < 1024; v++) pool.push_back(v);
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, pool.size() - 1);
            chain[i] = pool[k];
            pool.delete(k);
        end
        for (int i = 0; i < 39; i++) linkWrite(chain[i], chain[i + 1]);
        waitCycles(3);

        for (int r = 0; r < 8; r++) begin
            obs_upd.delete(); obs_ack.delete(); exp_upd.delete(); exp_ack.delete();
            fork
                begin
                    int nc, hp, hl, hpt, hc, cc;
                    nc = $urandom_range(1, 3);
                    for (int j = 0; j < nc; j++) begin
                        hp = chain[$urandom_range(0, 31)];
                        hl = $urandom_range(0, 512);
                        hpt = $urandom_range(0, 15);
                        hc = $urandom_range(0, 15);
                        modelCommand(hp, hpt, hc, hl);
                        applyStimulus(hp, hpt, hc, hl, cc);
                    end
                end
                begin
                    int lp, lcc;
                    ack_t a;
                    for (int t = 0; t < 40; t++) begin
                        if ($urandom_range(0, 3) == 0) begin
                            lp = chain[$urandom_range(0, 38)];
                            lookupReq(lp, lcc);
                            a.cyc = lcc + 4; a.ptr = 10'(nextp[lp]);
                            exp_ack.push_back(a);
                        end else begin
                            waitCycles(1);
                        end
                    end
                end
            join
            for (int w = 0; w < 300 && obs_upd.size() < exp_upd.size(); w++) waitCycles(1);
            waitCycles(8);
            checkOutput($sformatf("rnd%0d_upd_count", r), obs_upd.size(), exp_upd.size());
            for (int i = 0; i < exp_upd.size() && i < obs_upd.size(); i++) begin
                checkOutput($sformatf("rnd%0d_ptr%0d", r, i), obs_upd[i].ptr, exp_upd[i].ptr);
                checkOutput($sformatf("rnd%0d_port%0d", r, i), obs_upd[i].port, exp_upd[i].port);
                checkOutput($sformatf("rnd%0d_cnt%0d", r, i), obs_upd[i].cnt, exp_upd[i].cnt);
            end
            checkOutput($sformatf("rnd%0d_ack_count", r), obs_ack.size(), exp_ack.size());
            for (int i = 0; i < exp_ack.size() && i < obs_ack.size(); i++) begin
                checkOutput($sformatf("rnd%0d_ack_cyc%0d", r, i), obs_ack[i].cyc, exp_ack[i].cyc);
                checkOutput($sformatf("rnd%0d_ack_ptr%0d", r, i), obs_ack[i].ptr, exp_ack[i].ptr);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
